// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM state type, key layout and round mixing function.
// Used by both the encryption and decryption datapaths.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA        = 32'h9E3779B9;
  localparam logic [31:0] TEA_DEC_SUM_INIT = 32'hC6EF3720;
  localparam int          TEA_ROUNDS       = 32;

  typedef enum logic [1:0] {
    TEA_ST_IDLE       = 2'd0,
    TEA_ST_PROCESSING = 2'd1,
    TEA_ST_DONE       = 2'd2
  } tea_state_e;

  // k0 is the most significant word of the 128-bit key bus.
  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
  } tea_key_t;

  function automatic logic [31:0] tea_mix(input logic [31:0] v,
                                          input logic [31:0] ka,
                                          input logic [31:0] kb,
                                          input logic [31:0] sum);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decryption round: v1 is updated first, then v0
// is updated from the new v1, both using the same sum.
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  input  logic [31:0] sum,
  output logic [31:0] v0_next,
  output logic [31:0] v1_next
);

  logic [31:0] v1_upd;

  assign v1_upd  = v1 - tea_mix(v0, k2, k3, sum);
  assign v0_next = v0 - tea_mix(v1_upd, k0, k1, sum);
  assign v1_next = v1_upd;

endmodule

// File: rtl/tea_decryptor.sv
// Iterative TEA block decryptor with AXI-Stream style in/out handshakes.
// Define TEA_DEC_UNROLL2_EN to chain two rounds per cycle (16 busy cycles).
module tea_decryptor
  import tea_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_key,
  input  logic         i_axis_valid_s,
  output logic         o_axis_ready_s,
  input  logic [63:0]  i_axis_data_s,
  output logic         o_axis_valid_m,
  input  logic         i_axis_ready_m,
  output logic [63:0]  o_axis_data_m
);

  localparam logic [1:0] ST_IDLE       = TEA_ST_IDLE;
  localparam logic [1:0] ST_PROCESSING = TEA_ST_PROCESSING;
  localparam logic [1:0] ST_DONE       = TEA_ST_DONE;

  logic [1:0]  state_q, state_d;
  logic [31:0] v0_q, v0_d;
  logic [31:0] v1_q, v1_d;
  logic [31:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  tea_key_t    key_q, key_d;
  logic [63:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic [31:0] rnd_v0, rnd_v1;

`ifdef TEA_DEC_UNROLL2_EN
  localparam logic [31:0] SUM_STEP = TEA_DELTA + TEA_DELTA;
  localparam logic [4:0]  CNT_STEP = 5'd2;

  logic [31:0] mid_v0, mid_v1, sum_second;

  assign sum_second = sum_q - TEA_DELTA;

  tea_dec_round u_round0 (
    .v0(v0_q), .v1(v1_q),
    .k0(key_q.k0), .k1(key_q.k1), .k2(key_q.k2), .k3(key_q.k3),
    .sum(sum_q), .v0_next(mid_v0), .v1_next(mid_v1)
  );

  tea_dec_round u_round1 (
    .v0(mid_v0), .v1(mid_v1),
    .k0(key_q.k0), .k1(key_q.k1), .k2(key_q.k2), .k3(key_q.k3),
    .sum(sum_second), .v0_next(rnd_v0), .v1_next(rnd_v1)
  );
`else
  localparam logic [31:0] SUM_STEP = TEA_DELTA;
  localparam logic [4:0]  CNT_STEP = 5'd1;

  tea_dec_round u_round0 (
    .v0(v0_q), .v1(v1_q),
    .k0(key_q.k0), .k1(key_q.k1), .k2(key_q.k2), .k3(key_q.k3),
    .sum(sum_q), .v0_next(rnd_v0), .v1_next(rnd_v1)
  );
`endif

  // Counter value at the start of the cycle that completes the final round.
  localparam logic [4:0] CNT_LAST = 5'(TEA_ROUNDS - 32'(CNT_STEP));

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_axis_valid_s) begin
          v0_d    = i_axis_data_s[63:32];
          v1_d    = i_axis_data_s[31:0];
          key_d   = tea_key_t'(i_key);
          sum_d   = TEA_DEC_SUM_INIT;
          cnt_d   = 5'd0;
          state_d = ST_PROCESSING;
        end
      end
      ST_PROCESSING: begin
        v0_d  = rnd_v0;
        v1_d  = rnd_v1;
        sum_d = sum_q - SUM_STEP;
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 5'd0;
          data_d  = {rnd_v0, rnd_v1};
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_axis_ready_m) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_axis_ready_s = (state_q == ST_IDLE);
  assign o_axis_valid_m = valid_q;
  assign o_axis_data_m  = data_q;

endmodule
